read_mc: RTL and testbench

Multi-channel memory reader for the RTLinf datapath, the parametrised successor of the single-channel read stage. It generates addresses for NUM_CHANNELS independent memories and buffers returned words in per-channel FIFOs. Words are handed downstream (to distribute_in) under a valid/avail handshake, with credit-based flow control so no memory response is ever dropped. It adds per-channel base addresses, channel masking, optional strided addressing, iteration replay and an end-of-job pulse.

---
 rtl/read_mc_pkg.sv | 20 ++
 rtl/read_mc_if.sv | 41 ++++
 rtl/read_mc_chan.sv | 134 +++++++++++++
 rtl/read_mc.sv | 146 ++++++++++++++
 tb/tb_read_mc.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/read_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtlinf_read_mc_pkg
// Description : Shared FSM state type and FIFO sizing helper for read_mc.
// Revision    : 1.0
// ============================================================================
package rtlinf_read_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/read_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : read_mc_if
// Description : Configuration, memory-side and downstream signals of read_mc.
// Revision    : 1.0
// ============================================================================
interface read_mc_if #(
    parameter int NUM_CHANNELS           = 2,
    parameter int DATA_WIDTH             = 16,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int LOG_MAX_ADDRESS        = 16
);
    logic                                      configure;
    logic [LOG_MAX_ITERS-1:0]                  num_iters;
    logic [LOG_MAX_READS_PER_ITER-1:0]         num_reads_per_iter;
    logic [NUM_CHANNELS*LOG_MAX_ADDRESS-1:0]   base_address;
    logic [LOG_MAX_ADDRESS-1:0]                stride;
    logic [NUM_CHANNELS-1:0]                   channel_mask;
    logic [NUM_CHANNELS-1:0]                   request;
    logic [NUM_CHANNELS*LOG_MAX_ADDRESS-1:0]   address_out;
    logic [NUM_CHANNELS-1:0]                   valid_in;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]        data_in;
    logic [NUM_CHANNELS-1:0]                   avail_in;
    logic [NUM_CHANNELS-1:0]                   valid_out;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]        data_out;
    logic                                      done;

    modport master (
        input  configure, num_iters, num_reads_per_iter, base_address, stride,
               channel_mask, valid_in, data_in, avail_in,
        output request, address_out, valid_out, data_out, done
    );

    modport slave (
        output configure, num_iters, num_reads_per_iter, base_address, stride,
               channel_mask, valid_in, data_in, avail_in,
        input  request, address_out, valid_out, data_out, done
    );
endinterface
`default_nettype wire

// File: rtl/read_mc_chan.sv
`default_nettype none
// ============================================================================
// Module      : read_mc_chan
// Description : One read channel: address/iteration walk, credit, FIFO.
// Revision    : 1.0
// ============================================================================
module read_mc_chan
    import rtlinf_read_mc_pkg::*;
#(
    parameter int DATA_WIDTH             = 16,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int LOG_MAX_ADDRESS        = 16,
    parameter int FIFO_DEPTH             = 4
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_start,
    input  wire logic                              i_enable,
    input  wire logic                              i_busy,
    input  wire logic [LOG_MAX_ITERS-1:0]          i_iters,
    input  wire logic [LOG_MAX_READS_PER_ITER-1:0] i_reads,
    input  wire logic [LOG_MAX_ADDRESS-1:0]        i_base,
    input  wire logic [LOG_MAX_ADDRESS-1:0]        i_inc,
    input  wire logic                              i_valid_in,
    input  wire logic [DATA_WIDTH-1:0]             i_data_in,
    input  wire logic                              i_avail_in,
    output logic                                   o_request,
    output logic [LOG_MAX_ADDRESS-1:0]             o_address_out,
    output logic                                   o_valid_out,
    output logic [DATA_WIDTH-1:0]                  o_data_out,
    output logic                                   o_words_left,
    output logic                                   o_quiet
);
    localparam int c_ptr_w = fifo_ptr_w(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]             r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]                r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]                r_count, r_outstanding;
    logic                              r_valid, r_request, r_left;
    logic [LOG_MAX_ADDRESS-1:0]        r_addr, r_next_addr;
    logic [LOG_MAX_READS_PER_ITER-1:0] r_j;
    logic [LOG_MAX_ITERS-1:0]          r_iter;

    logic                              w_push, w_pop, w_credit, w_issue;
    logic                              w_last_j, w_last_iter;
    logic [c_cnt_w-1:0]                w_count_nxt, w_out_nxt;
    logic [LOG_MAX_ADDRESS-1:0]        w_cur_addr;
    logic [LOG_MAX_READS_PER_ITER-1:0] w_cur_j;
    logic [LOG_MAX_ITERS-1:0]          w_cur_iter;

    assign w_push = i_busy && i_valid_in;
    assign w_pop  = r_valid && i_avail_in;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + c_cnt_w'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - c_cnt_w'(1);
        w_out_nxt = r_outstanding;
        if (r_request && !w_push)
            w_out_nxt = r_outstanding + c_cnt_w'(1);
        else if (!r_request && w_push)
            w_out_nxt = r_outstanding - c_cnt_w'(1);
    end

    // Credit is judged on next-cycle occupancy so the registered request
    // never overcommits the FIFO.
    assign w_credit = ({1'b0, w_out_nxt} + {1'b0, w_count_nxt}) < c_depth;
    assign w_issue  = i_start ? i_enable : (i_busy && r_left && w_credit);

    assign w_cur_addr  = i_start ? i_base : r_next_addr;
    assign w_cur_j     = i_start ? '0 : r_j;
    assign w_cur_iter  = i_start ? '0 : r_iter;
    assign w_last_j    = (w_cur_j == i_reads - LOG_MAX_READS_PER_ITER'(1));
    assign w_last_iter = (w_cur_iter == i_iters - LOG_MAX_ITERS'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_request     <= 1'b0;
            r_addr        <= '0;
            r_next_addr   <= '0;
            r_j           <= '0;
            r_iter        <= '0;
            r_left        <= 1'b0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_request     <= w_issue;
            r_outstanding <= w_out_nxt;
            r_count       <= w_count_nxt;
            r_valid       <= (w_count_nxt != '0);
            if (w_issue) begin
                r_addr <= w_cur_addr;
                if (w_last_j) begin
                    r_j         <= '0;
                    r_next_addr <= i_base;
                    r_iter      <= w_cur_iter + LOG_MAX_ITERS'(1);
                    r_left      <= !w_last_iter;
                end else begin
                    r_j         <= w_cur_j + LOG_MAX_READS_PER_ITER'(1);
                    r_next_addr <= w_cur_addr + i_inc;
                    r_iter      <= w_cur_iter;
                    r_left      <= 1'b1;
                end
            end else if (i_start) begin
                r_left <= 1'b0;
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data_in;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
    end

    assign o_request     = r_request;
    assign o_address_out = r_addr;
    assign o_valid_out   = r_valid;
    assign o_data_out    = r_mem[r_rd_ptr];
    assign o_words_left  = r_left;
    assign o_quiet       = !r_request && (r_outstanding == '0) && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/read_mc.sv
`default_nettype none
// ============================================================================
// Module      : read_mc
// Description : Multi-channel credit-flow memory reader; READ_MC_STRIDE_EN
//               enables strided addressing (otherwise increment is 1).
// Revision    : 1.0
// ============================================================================
module read_mc
    import rtlinf_read_mc_pkg::*;
#(
    parameter int NUM_CHANNELS           = 2,
    parameter int DATA_WIDTH             = 16,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int LOG_MAX_ADDRESS        = 16,
    parameter int MEM_LATENCY            = 1,
    parameter int FIFO_DEPTH             = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    read_mc_if.master  bus
);
    state_t                                  r_state;
    logic                                    r_done;
    logic [LOG_MAX_ITERS-1:0]                r_iters;
    logic [LOG_MAX_READS_PER_ITER-1:0]       r_reads;
    logic [NUM_CHANNELS*LOG_MAX_ADDRESS-1:0] r_base;
    logic [NUM_CHANNELS-1:0]                 r_mask;

    logic                                    w_idle, w_start, w_any;
    logic [LOG_MAX_ITERS-1:0]                w_iters;
    logic [LOG_MAX_READS_PER_ITER-1:0]       w_reads;
    logic [NUM_CHANNELS*LOG_MAX_ADDRESS-1:0] w_base;
    logic [LOG_MAX_ADDRESS-1:0]              w_inc;
    logic [NUM_CHANNELS-1:0]                 w_enable, w_left, w_quiet;
    logic [NUM_CHANNELS-1:0]                 w_request, w_valid_out;
    logic [NUM_CHANNELS*LOG_MAX_ADDRESS-1:0] w_address;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]      w_data_out;

    if (FIFO_DEPTH < MEM_LATENCY + 2) begin : g_depth_check
        $error("read_mc: FIFO_DEPTH must be at least MEM_LATENCY+2");
    end

    assign w_idle   = (r_state == ST_IDLE);
    assign w_start  = w_idle && bus.configure;
    // Channels see the live inputs on the start cycle, latched values after.
    assign w_iters  = w_idle ? bus.num_iters          : r_iters;
    assign w_reads  = w_idle ? bus.num_reads_per_iter : r_reads;
    assign w_base   = w_idle ? bus.base_address       : r_base;
    assign w_any    = (|bus.channel_mask) && (bus.num_iters != '0)
                      && (bus.num_reads_per_iter != '0);
    assign w_enable = bus.channel_mask & {NUM_CHANNELS{w_any}};

`ifdef READ_MC_STRIDE_EN
    logic [LOG_MAX_ADDRESS-1:0] r_stride;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stride <= '0;
        else if (w_start)
            r_stride <= bus.stride;
    end

    assign w_inc = w_idle ? bus.stride : r_stride;
`else
    logic w_unused_stride;

    assign w_unused_stride = ^bus.stride;
    assign w_inc           = LOG_MAX_ADDRESS'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_iters <= '0;
            r_reads <= '0;
            r_base  <= '0;
            r_mask  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_iters <= bus.num_iters;
                        r_reads <= bus.num_reads_per_iter;
                        r_base  <= bus.base_address;
                        r_mask  <= bus.channel_mask;
                        if (w_any)
                            r_state <= ST_RUN;
                        else
                            r_done  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_left == '0)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (&w_quiet) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        read_mc_chan #(
            .DATA_WIDTH             (DATA_WIDTH),
            .LOG_MAX_ITERS          (LOG_MAX_ITERS),
            .LOG_MAX_READS_PER_ITER (LOG_MAX_READS_PER_ITER),
            .LOG_MAX_ADDRESS        (LOG_MAX_ADDRESS),
            .FIFO_DEPTH             (FIFO_DEPTH)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .i_start       (w_start),
            .i_enable      (w_enable[c]),
            .i_busy        (!w_idle && r_mask[c]),
            .i_iters       (w_iters),
            .i_reads       (w_reads),
            .i_base        (w_base[c*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS]),
            .i_inc         (w_inc),
            .i_valid_in    (bus.valid_in[c]),
            .i_data_in     (bus.data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_avail_in    (bus.avail_in[c]),
            .o_request     (w_request[c]),
            .o_address_out (w_address[c*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS]),
            .o_valid_out   (w_valid_out[c]),
            .o_data_out    (w_data_out[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_words_left  (w_left[c]),
            .o_quiet       (w_quiet[c])
        );
    end

    assign bus.request     = w_request;
    assign bus.address_out = w_address;
    assign bus.valid_out   = w_valid_out;
    assign bus.data_out    = w_data_out;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_read_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_read_mc
// Description : Scoreboard bench for read_mc with a fixed-latency memory model.
// Revision    : 1.0
// ============================================================================
module tb_read_mc;
    localparam int NC = 2;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    read_mc_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .LOG_MAX_ITERS(16),
                 .LOG_MAX_READS_PER_ITER(16), .LOG_MAX_ADDRESS(AW)) bus ();

    read_mc #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .LOG_MAX_ITERS(16),
              .LOG_MAX_READS_PER_ITER(16), .LOG_MAX_ADDRESS(AW),
              .MEM_LATENCY(1), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [15:0] exp_addr_q [NC][$];
    logic [15:0] exp_data_q [NC][$];
    int          inflight  [NC];
    logic        pend_v    [NC];
    logic [15:0] pend_a    [NC];
    int          first_req [NC];
    int          last_req  [NC];
    int          first_vo  [NC];
    int          n_req     [NC];
    int          n_vo      [NC];
    int          last_xfer, done_cnt, done_cyc, t_cfg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [15:0] mem_f(input int c, input logic [15:0] a);
        return a ^ ((c == 0) ? 16'h3C5A : 16'hC3A5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int c = 0; c < NC; c++) begin
            first_req[c] = -1;
            last_req[c]  = -1;
            first_vo[c]  = -1;
            n_req[c]     = 0;
            n_vo[c]      = 0;
        end
        last_xfer = -1;
        done_cnt  = 0;
        done_cyc  = -1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor + memory model, all at the falling edge.
    initial begin
        logic [15:0] e;
        bus.valid_in = '0;
        bus.data_in  = '0;
        for (int c = 0; c < NC; c++) begin
            pend_v[c]   = 1'b0;
            pend_a[c]   = '0;
            inflight[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int c = 0; c < NC; c++) begin
                    if (bus.request[c]) begin
                        chk("credit", 32'(inflight[c] < FD), 32'd1);
                        if (exp_addr_q[c].size() == 0) begin
                            chk("extra_request", 32'd1, 32'd0);
                        end else begin
                            e = exp_addr_q[c].pop_front();
                            chk("address", 32'(bus.address_out[c*AW +: AW]), 32'(e));
                        end
                        inflight[c]++;
                        n_req[c]++;
                        if (first_req[c] < 0) first_req[c] = cyc;
                        last_req[c] = cyc;
                    end
                    if (bus.valid_out[c]) begin
                        n_vo[c]++;
                        if (first_vo[c] < 0) first_vo[c] = cyc;
                    end
                    if (bus.valid_out[c] && bus.avail_in[c]) begin
                        if (exp_data_q[c].size() == 0) begin
                            chk("extra_word", 32'd1, 32'd0);
                        end else begin
                            e = exp_data_q[c].pop_front();
                            chk("data", 32'(bus.data_out[c*DW +: DW]), 32'(e));
                        end
                        inflight[c]--;
                        last_xfer = cyc;
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
            for (int c = 0; c < NC; c++) begin
                bus.valid_in[c]          = pend_v[c] && !rst;
                bus.data_in[c*DW +: DW]  = mem_f(c, pend_a[c]);
                pend_v[c]                = bus.request[c] && !rst;
                pend_a[c]                = bus.address_out[c*AW +: AW];
            end
        end
    end

    task automatic start_job(input logic [15:0] iters, input logic [15:0] reads,
                             input logic [15:0] b0, input logic [15:0] b1,
                             input logic [15:0] strd, input logic [1:0] mask);
        logic [15:0] inc, a, b;
`ifdef READ_MC_STRIDE_EN
        inc = strd;
`else
        inc = 16'd1;
`endif
        clear_stats();
        for (int c = 0; c < NC; c++) begin
            b = (c == 0) ? b0 : b1;
            if (mask[c]) begin
                for (int i = 0; i < int'(iters); i++)
                    for (int j = 0; j < int'(reads); j++) begin
                        a = b + 16'(j) * inc;
                        exp_addr_q[c].push_back(a);
                        exp_data_q[c].push_back(mem_f(c, a));
                    end
            end
        end
        bus.num_iters          = iters;
        bus.num_reads_per_iter = reads;
        bus.base_address       = {b1, b0};
        bus.stride             = strd;
        bus.channel_mask       = mask;
        bus.configure          = 1'b1;
        t_cfg = cyc;
        tick();
        bus.configure          = 1'b0;
        bus.num_iters          = 16'd7;
        bus.num_reads_per_iter = 16'd3;
        bus.base_address       = 32'hDEAD_BEEF;
        bus.stride             = 16'd5;
        bus.channel_mask       = ~mask;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) tick();
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (4) tick();
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("done_after_xfer", 32'(done_cyc > last_xfer), 32'd1);
        for (int c = 0; c < NC; c++) begin
            chk("addr_left", 32'(exp_addr_q[c].size()), 32'd0);
            chk("data_left", 32'(exp_data_q[c].size()), 32'd0);
            chk("inflight_end", 32'(inflight[c]), 32'd0);
        end
    endtask

    initial begin
        bus.configure          = 1'b0;
        bus.num_iters          = '0;
        bus.num_reads_per_iter = '0;
        bus.base_address       = '0;
        bus.stride             = '0;
        bus.channel_mask       = '0;
        bus.avail_in           = '1;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_request", 32'(bus.request), 32'd0);
        chk("rst_address", 32'(bus.address_out), 32'd0);
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // single channel, two passes of four words
        start_job(16'd2, 16'd4, 16'h0010, 16'h0000, 16'd1, 2'b01);
        wait_done(200);
        chk("first_req_lat", 32'(first_req[0]), 32'(t_cfg + 1));
        chk("first_vo_lat", 32'(first_vo[0]), 32'(t_cfg + 3));
        chk("throughput", 32'(last_req[0] - first_req[0]), 32'd7);
        chk("n_req_job1", 32'(n_req[0]), 32'd8);

        // channel 0 masked off
        start_job(16'd1, 16'd4, 16'h0000, 16'h0100, 16'd1, 2'b10);
        wait_done(200);
        chk("masked_req", 32'(n_req[0]), 32'd0);
        chk("masked_vo", 32'(n_vo[0]), 32'd0);
        chk("ch1_req", 32'(n_req[1]), 32'd4);

        // downstream stall fills exactly the credit window
        start_job(16'd1, 16'd16, 16'h0200, 16'h0000, 16'd1, 2'b01);
        repeat (4) tick();
        bus.avail_in = '0;
        repeat (20) tick();
        chk("stall_fill", 32'(inflight[0]), 32'd4);
        bus.avail_in = '1;
        wait_done(300);
        chk("stall_n_req", 32'(n_req[0]), 32'd16);

        // strided walk across the address wrap
        start_job(16'd1, 16'd3, 16'hFFFE, 16'h0000, 16'd3, 2'b01);
        wait_done(200);

        // empty jobs finish on the next cycle
        start_job(16'd4, 16'd0, 16'h0000, 16'h0000, 16'd1, 2'b11);
        wait_done(50);
        chk("zero_reads_done", 32'(done_cyc), 32'(t_cfg + 1));
        chk("zero_reads_req", 32'(n_req[0] + n_req[1]), 32'd0);
        start_job(16'd2, 16'd2, 16'h0000, 16'h0000, 16'd1, 2'b00);
        wait_done(50);
        chk("no_mask_done", 32'(done_cyc), 32'(t_cfg + 1));

        // a second configure while running is ignored
        start_job(16'd2, 16'd5, 16'h0040, 16'h0080, 16'd1, 2'b11);
        tick();
        bus.num_reads_per_iter = 16'd9;
        bus.base_address       = 32'h1234_5678;
        bus.channel_mask       = 2'b11;
        bus.configure          = 1'b1;
        tick();
        bus.configure          = 1'b0;
        wait_done(300);

        // both channels with random downstream back-pressure
        start_job(16'd3, 16'd5, 16'h0300, 16'h7FFD, 16'd1, 2'b11);
        for (int k = 0; k < 600 && done_cnt == 0; k++) begin
            for (int c = 0; c < NC; c++)
                bus.avail_in[c] = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.avail_in = '1;
        wait_done(300);

        // reset in the middle of a job
        start_job(16'd2, 16'd6, 16'h0500, 16'h0600, 16'd1, 2'b11);
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_request", 32'(bus.request), 32'd0);
        chk("abort_address", 32'(bus.address_out), 32'd0);
        chk("abort_valid_out", 32'(bus.valid_out), 32'd0);
        chk("abort_data_out", 32'(bus.data_out), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        for (int c = 0; c < NC; c++) begin
            exp_addr_q[c].delete();
            exp_data_q[c].delete();
            inflight[c] = 0;
        end
        clear_stats();
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_no_req", 32'(n_req[0] + n_req[1]), 32'd0);
        start_job(16'd1, 16'd4, 16'h0500, 16'h0600, 16'd1, 2'b11);
        wait_done(200);
        chk("restart_first_req", 32'(first_req[0]), 32'(t_cfg + 1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
